contador_programa_branch: RTL
=============================

// Module: contador_programa_branch
// PURPOSE
// Consumer side of the branch-decision path. Takes the taken-branch signal (branch & comparacion)
// plus the jump signal, and owns the program counter. Redirects the PC to the branch/jump target
// and flushes the younger wrong-path instructions for a fixed number of cycles.
// Sits between the branch AND logic / branch adder and the instruction memory address port.
// PARAMETERS
// XLEN          32  width of PC and target
// RESET_PC      0   PC value loaded on reset (must be 4-byte aligned)
// FLUSH_CYCLES  2   cycles flush stays high after a redirect (1..15)
// PORTS
// clk             in   1     single clock, rising edge
// rst             in   1     asynchronous, active-high reset
// and_out         in   1     branch taken (branch & comparacion)
// jump            in   1     unconditional jump (jal/jalr) taken
// target          in   XLEN  branch/jump target address
// stall           in   1     hazard stall: hold PC
// pc              out  XLEN  current fetch address (registered)
// pc_plus4        out  XLEN  pc + 4, combinational, modulo 2^XLEN
// fetch_valid     out  1     fetch at pc is architecturally valid
// flush           out  1     kill younger wrong-path instructions in IF/ID
// error_desalineado out 1    one-cycle pulse: redirect target[1:0] != 0
// contador_saltos out  16    count of accepted redirects, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset (async, rst=1): pc=RESET_PC, fetch_valid=0, flush=0, error_desalineado=0,
//   contador_saltos=0, state=RUN, flush counter=0. First edge with rst=0 sets fetch_valid=1.
// - redirect = (and_out | jump) & (state==RUN) & fetch_valid.
// - State RUN, per edge:
//   redirect -> pc <= {target[XLEN-1:2],2'b00}; flush <= 1; cnt <= FLUSH_CYCLES-1;
//     state <= (FLUSH_CYCLES==1) ? RUN : FLUSH; contador_saltos++ (saturating);
//     error_desalineado <= (target[1:0]!=0).
//   else if stall -> pc holds; flush <= 0.
//   else -> pc <= pc+4 (wraps 0xFFFFFFFC -> 0x00000000); flush <= 0.
// - Redirect has priority over stall (a stalled branch still redirects).
// - State FLUSH: flush stays 1. cnt decrements each edge regardless of stall.
//   When cnt==0 -> flush <= 0 and state <= RUN. pc advances by 4 unless stall.
//   and_out/jump are ignored in FLUSH (wrong-path branches). They are not counted and cause no pulse.
// - Latency: the redirect takes effect on the edge after and_out is sampled.
//   flush is high exactly FLUSH_CYCLES cycles starting that same edge.
// - error_desalineado is high for exactly 1 cycle per misaligned redirect; otherwise it is 0.
// - Reset mid-FLUSH: abandon immediately and apply the reset values; no residual flush.
// - and_out and jump together: a single redirect to target, counted once.
// TESTING
// 1 Reset: rst=1 then 0, no branch, 4 cycles -> pc 0,4,8,12; fetch_valid 0 then 1; flush=0.
// 2 Taken: at pc=8, and_out=1, target=0x40 -> next pc=0x40; flush=1 for 2 cycles;
//   pc=0x44,0x48; contador_saltos=1.
// 3 Ignored in FLUSH: and_out=1 on the 2nd flush cycle, target=0x100 -> pc continues 0x48;
//   counter stays 1.
// 4 Stall+branch: stall=1 and jump=1, target=0x80 -> pc=0x80 (redirect wins).
//   Stall alone for 3 cycles -> pc held.
// 5 Misaligned/wrap: target=0x42 -> pc=0x40 and a 1-cycle error pulse.
//   pc=0xFFFFFFFC with no branch -> pc=0x0.
// 6 Reset mid-flush: rst pulsed during flush=1 -> pc=RESET_PC, flush=0, counter=0 immediately.

Source files
------------

// File: rtl/contador_programa_branch.sv
// contador_programa_branch: program counter with branch/jump redirect, wrong-path flush and redirect counter
// Ports: clk, rst (async, active-high); and_out/jump redirect requests to target; stall holds pc;
// pc registered fetch address, pc_plus4 combinational pc+4; fetch_valid, flush, error_desalineado
// (one-cycle misaligned-target pulse), contador_saltos (saturating count of accepted redirects).
module contador_programa_branch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            and_out,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            flush,
  output logic            error_desalineado,
  output logic [15:0]     contador_saltos
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [XLEN-1:0] pc_n;
  logic [15:0] saltos_n;
  logic redirect, flush_n, err_n, in_flush, last;
  assign pc_plus4 = pc + XLEN'(4);
  assign redirect = (and_out | jump) & (state == RUN) & fetch_valid;
  assign in_flush = state == FLUSH;
  assign last = in_flush && cnt == 4'd0;
  // Redirect beats stall; during FLUSH the pc keeps fetching down the new path.
  always_comb begin
    pc_n = redirect ? {target[XLEN-1:2], 2'b00} : stall ? pc : pc_plus4;
    flush_n = redirect | (in_flush & ~last);
    cnt_n = redirect ? CNT_INIT : (in_flush && !last) ? cnt - 4'd1 : cnt;
    state_n = redirect ? (FLUSH_CYCLES == 1 ? RUN : FLUSH) : last ? RUN : state;
    err_n = redirect && target[1:0] != 2'b00;
    saltos_n = (redirect && contador_saltos != 16'hFFFF) ? contador_saltos + 16'd1 : contador_saltos;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      pc <= RESET_PC;
      fetch_valid <= 1'b0;
      flush <= 1'b0;
      error_desalineado <= 1'b0;
      contador_saltos <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc <= pc_n;
      fetch_valid <= 1'b1;
      flush <= flush_n;
      error_desalineado <= err_n;
      contador_saltos <= saltos_n;
    end
  end
endmodule
